target_feeder: RTL and testbench
================================

TARGET_FEEDER -- requirements
Module: target_feeder

Interface
REQ-001 Parameter LENGTH, default 128: PE count of the downstream systolic scoring array.
REQ-002 Parameter FIFO_DEPTH, default 16, power of two: per-lane base buffer depth.
REQ-003 Parameter GAP_SLOTS, default LENGTH+2: lane-own slots of enable-low held between two sequences of one lane.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s0_valid / s0_last  in  1 / 1  lane-0 base stream valid, and last-base-of-sequence marker.
REQ-007 s0_base  in  2  lane-0 base (A=10, G=11, T=00, C=01).
REQ-008 s0_ready  out  1  lane-0 accept; transfer when s0_valid and s0_ready.
REQ-009 s1_valid, s1_last, s1_base, s1_ready: same as REQ-006 to REQ-008 for lane 1.
REQ-010 data_out  out  2  base to the array's data_in.
REQ-011 en0 / en1  out  1 / 1  lane enables to the array; high for the whole sequence.
REQ-012 phase  out  1  slot owner of the current data_out (0 = lane 0).
REQ-013 err0 / err1  out  1 / 1  sticky underrun flags.
REQ-014 err_clr  in  1  clears err0 and err1.
REQ-015 busy  out  1  either lane not IDLE or either FIFO non-empty.

Function
REQ-016 phase shall toggle every cycle; lane p shall own the cycles where phase==p.
REQ-017 All outputs shall be registered, with one-cycle latency from the FIFO pop to data_out/enX.
REQ-018 Each lane shall have a FIFO storing {last, base}; sX_ready shall equal FIFO-not-full; a simultaneous push and pop on a full FIFO shall be refused (ready low).
REQ-019 Each lane FSM shall have the states IDLE, STREAM, DISCARD, GAP, and shall change state only on its own slot.
REQ-020 IDLE -> STREAM when the FIFO holds an entry with last=1 or the FIFO is full; the first pop shall occur on that same slot.
REQ-021 STREAM: pop one entry per own slot, drive data_out=base and enX=1; a popped last=1 shall go to GAP with enX=0 from the next own slot.
REQ-022 STREAM with an empty FIFO on an own slot shall be an underrun: enX=0, errX set, go to DISCARD.
REQ-023 DISCARD: pop and drop entries, enX=0, until last=1 is popped, then go to GAP.
REQ-024 GAP: enX=0; a counter shall count own slots up to GAP_SLOTS, then go to IDLE.
REQ-025 On an own slot with no valid base driven (IDLE, GAP, DISCARD), data_out shall be 2'b00.
REQ-026 enX shall hold its value on the other lane's slots.
REQ-027 A single-base sequence (first entry has last=1) shall give exactly one own slot of enX=1.
REQ-028 When err_clr and an underrun occur in the same cycle, set shall win.
REQ-029 The GAP counter width shall be clog2(GAP_SLOTS+1); FIFO pointers shall wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.

Reset
REQ-030 On rst: phase=0, data_out=0, en0=en1=0, err0=err1=0, both FSMs IDLE, FIFOs empty, counters 0, sX_ready=0 during the reset cycle.
REQ-031 A reset mid-sequence shall drop all buffered bases and force en0=en1=0 on the next edge, with no GAP enforced.

Structure
REQ-032 The nucleotide encodings and state encodings shall live in the shared package sw_pkg.
REQ-033 The FIFO shall be one sub-module, feeder_fifo, instantiated once per lane.
REQ-034 The lane FSM shall be written once and replicated with a generate loop.

Verification
REQ-035 Scenario: lane 0 sequence A,G,T,C (last on C) -> data_out 10,11,00,01 on phase 0 cycles, en0 high 8 cycles, then en0 low >= 2*GAP_SLOTS cycles.
REQ-036 Scenario: both lanes loaded simultaneously -> data_out interleaves lane0/lane1 bases per phase, en0 and en1 both high, no err.
REQ-037 Scenario: lane 1 with 16 bases and no last -> streaming starts on full; withhold the 17th base -> err1=1, en1 falls, remaining bases dropped up to last.
REQ-038 Scenario: a single-base sequence with last=1 -> en0 high for exactly one phase-0 slot (2 cycles).
REQ-039 Scenario: rst asserted mid-stream -> next edge en0=en1=0, busy=0, err cleared; new sequence accepted immediately.
REQ-040 Scenario: err_clr and an underrun in the same cycle -> errX=1.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared encodings for the target feeder: nucleotide codes, lane FSM states
// and the entry format held in each lane buffer.
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'b10;
  localparam logic [1:0] BASE_G = 2'b11;
  localparam logic [1:0] BASE_T = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;

  typedef enum logic [1:0] {
    LANE_IDLE    = 2'd0,
    LANE_STREAM  = 2'd1,
    LANE_DISCARD = 2'd2,
    LANE_GAP     = 2'd3
  } lane_state_e;

  typedef struct packed {
    logic       last;
    logic [1:0] base;
  } fifo_entry_t;

endpackage

// File: rtl/feeder_fifo.sv
// Per-lane base buffer holding {last, base}. Pointers carry an extra wrap bit
// so full and empty are told apart; a running count of buffered last markers
// tells the lane FSM that a complete sequence is waiting.
module feeder_fifo
  import sw_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       push_last,
  input  logic [1:0] push_base,
  input  logic       pop,
  output logic       pop_last,
  output logic [1:0] pop_base,
  output logic       empty,
  output logic       full,
  output logic       has_last
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LCW = $clog2(DEPTH + 1);

  fifo_entry_t      mem_q [DEPTH];
  fifo_entry_t      rd_entry;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LCW-1:0]   last_cnt_q, last_cnt_d;
  logic             push_ok, pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign has_last = (last_cnt_q != '0);
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_last = rd_entry.last;
  assign pop_base = rd_entry.base;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Next pointers and count of buffered last markers.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_cnt_d = last_cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    if (push_ok && push_last && !(pop_ok && rd_entry.last)) last_cnt_d = last_cnt_q + LCW'(1);
    if (!(push_ok && push_last) && pop_ok && rd_entry.last) last_cnt_d = last_cnt_q - LCW'(1);
  end

  // Pointer/count registers; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_cnt_q <= last_cnt_d;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= '{last: push_last, base: push_base};
  end

endmodule

// File: rtl/target_feeder.sv
// Time-multiplexes two base streams onto one systolic-array input. phase
// toggles every cycle; lane p owns the output cycle where phase==p and makes
// its decision (pop, state change) in the cycle before, so data_out/enX are
// registered one cycle after the pop.
// Handshake: a base transfers on a rising edge where sX_valid && sX_ready;
// sX_ready is FIFO-not-full (low in reset) and never depends on sX_valid.
module target_feeder
  import sw_pkg::*;
#(
  parameter int LENGTH     = 128,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_SLOTS  = LENGTH + 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  input  logic       s0_last,
  input  logic [1:0] s0_base,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic       s1_last,
  input  logic [1:0] s1_base,
  output logic       s1_ready,
  output logic [1:0] data_out,
  output logic       en0,
  output logic       en1,
  output logic       phase,
  output logic       err0,
  output logic       err1,
  input  logic       err_clr,
  output logic       busy,
  output logic [3:0] dbg_state
);

  localparam int GW = $clog2(GAP_SLOTS + 1);

  logic [1:0] s_valid, s_last, s_ready, f_push;
  logic [1:0] f_empty, f_full, f_has_last, f_rd_last;
  logic [1:0] lane_pop, lane_drive, lane_underrun, lane_act, lane_busy;
  logic [1:0] s_base     [2];
  logic [1:0] f_rd_base  [2];
  logic [1:0] lane_state [2];

  logic       phase_q, phase_d;
  logic [1:0] data_out_q, data_out_d;
  logic [1:0] en_q, en_d, err_q, err_d;

  assign s_valid   = {s1_valid, s0_valid};
  assign s_last    = {s1_last, s0_last};
  assign s_base[0] = s0_base;
  assign s_base[1] = s1_base;
  assign s_ready   = ~f_full & {2{~rst}};
  assign f_push    = s_valid & s_ready;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam logic LANE_ID = (g == 1);

    lane_state_e   state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          pop, drive, underrun;

    feeder_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (f_push[g]),
      .push_last (s_last[g]),
      .push_base (s_base[g]),
      .pop       (pop),
      .pop_last  (f_rd_last[g]),
      .pop_base  (f_rd_base[g]),
      .empty     (f_empty[g]),
      .full      (f_full[g]),
      .has_last  (f_has_last[g])
    );

    assign lane_act[g]      = (phase_q != LANE_ID);
    assign lane_pop[g]      = pop;
    assign lane_drive[g]    = drive;
    assign lane_underrun[g] = underrun;
    assign lane_busy[g]     = (state_q != LANE_IDLE) || !f_empty[g];
    assign lane_state[g]    = state_q;

    // Lane sequencing; acts only in the cycle that feeds its own output slot.
    always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      pop       = 1'b0;
      drive     = 1'b0;
      underrun  = 1'b0;
      if (lane_act[g]) begin
        case (state_q)
          LANE_IDLE: begin
            if (f_has_last[g] || f_full[g]) begin
              pop     = 1'b1;
              drive   = 1'b1;
              state_d = f_rd_last[g] ? LANE_GAP : LANE_STREAM;
            end
          end
          LANE_STREAM: begin
            if (f_empty[g]) begin
              underrun = 1'b1;
              state_d  = LANE_DISCARD;
            end else begin
              pop   = 1'b1;
              drive = 1'b1;
              if (f_rd_last[g]) state_d = LANE_GAP;
            end
          end
          LANE_DISCARD: begin
            if (!f_empty[g]) begin
              pop = 1'b1;
              if (f_rd_last[g]) state_d = LANE_GAP;
            end
          end
          LANE_GAP: begin
            if (gap_cnt_q == GW'(GAP_SLOTS - 1)) begin
              gap_cnt_d = '0;
              state_d   = LANE_IDLE;
            end else begin
              gap_cnt_d = gap_cnt_q + GW'(1);
            end
          end
          default: state_d = LANE_IDLE;
        endcase
      end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= LANE_IDLE;
        gap_cnt_q <= '0;
      end else begin
        state_q   <= state_d;
        gap_cnt_q <= gap_cnt_d;
      end
    end
  end

  // Output slot mux, enable hold on the other lane's slot, sticky error flags.
  always_comb begin
    phase_d    = ~phase_q;
    data_out_d = 2'b00;
    en_d       = en_q;
    err_d      = err_q;
    for (int i = 0; i < 2; i++) begin
      if (lane_drive[i]) data_out_d = f_rd_base[i];
      if (lane_act[i]) en_d[i] = lane_drive[i];
      if (lane_underrun[i]) err_d[i] = 1'b1;
      else if (err_clr) err_d[i] = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 1'b0;
      data_out_q <= 2'b00;
      en_q       <= 2'b00;
      err_q      <= 2'b00;
    end else begin
      phase_q    <= phase_d;
      data_out_q <= data_out_d;
      en_q       <= en_d;
      err_q      <= err_d;
    end
  end

  assign data_out  = data_out_q;
  assign phase     = phase_q;
  assign en0       = en_q[0];
  assign en1       = en_q[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign s0_ready  = s_ready[0];
  assign s1_ready  = s_ready[1];
  assign busy      = |lane_busy;
  assign dbg_state = {lane_state[1], lane_state[0]};

endmodule

// File: tb/tb_target_feeder.sv
// Bench for target_feeder: cycle tables for the single-lane and two-lane
// sequences, hand-written sequences for gap length, single base, underrun,
// err_clr/underrun collision and mid-stream reset.
module tb_target_feeder;
  import sw_pkg::*;

  localparam int LENGTH = 8;
  localparam int DEPTH  = 16;
  localparam int GS     = LENGTH + 2;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk, rst;
  logic       s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic [1:0] s0_base, s1_base, data_out;
  logic       en0, en1, phase, err0, err1, err_clr, busy;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int en1_hi_cnt = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic s0v; logic s0l; logic [1:0] s0b;
    logic s1v; logic s1l; logic [1:0] s1b;
    logic e_ph; logic [1:0] e_data; logic e_en0; logic e_en1;
  } vec_t;
  vec_t vecs[22];

  target_feeder #(.LENGTH(LENGTH), .FIFO_DEPTH(DEPTH), .GAP_SLOTS(GS)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_last(s0_last), .s0_base(s0_base), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_last(s1_last), .s1_base(s1_base), .s1_ready(s1_ready),
    .data_out(data_out), .en0(en0), .en1(en1), .phase(phase),
    .err0(err0), .err1(err1), .err_clr(err_clr), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts lane-1 enable-high cycles, sampled mid-cycle.
  always @(negedge clk) if (en1 === 1'b1) en1_hi_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_valid = 0; s0_last = 0; s0_base = 2'b00;
    s1_valid = 0; s1_last = 0; s1_base = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic push_base(input int lane, input logic [1:0] b, input logic l);
    int k;
    k = 0;
    while (((lane == 0) ? s0_ready : s1_ready) !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check($sformatf("lane%0d ready before push", lane), (lane == 0) ? s0_ready : s1_ready, 1);
    if (lane == 0) begin s0_valid = 1; s0_base = b; s0_last = l; end
    else begin s1_valid = 1; s1_base = b; s1_last = l; end
    tick();
    idle_inputs();
  endtask

  function automatic vec_t mk(logic s0v, logic s0l, logic [1:0] s0b,
                              logic s1v, logic s1l, logic [1:0] s1b,
                              logic ph, logic [1:0] d, logic e0, logic e1);
    vec_t v;
    v.s0v = s0v; v.s0l = s0l; v.s0b = s0b;
    v.s1v = s1v; v.s1l = s1l; v.s1b = s1b;
    v.e_ph = ph; v.e_data = d; v.e_en0 = e0; v.e_en1 = e1;
    return v;
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      s0_valid = vecs[i].s0v; s0_last = vecs[i].s0l; s0_base = vecs[i].s0b;
      s1_valid = vecs[i].s1v; s1_last = vecs[i].s1l; s1_base = vecs[i].s1b;
      tick();
      check($sformatf("vec%0d phase", i), phase, vecs[i].e_ph);
      check($sformatf("vec%0d data_out", i), data_out, vecs[i].e_data);
      check($sformatf("vec%0d en0", i), en0, vecs[i].e_en0);
      check($sformatf("vec%0d en1", i), en1, vecs[i].e_en1);
      check($sformatf("vec%0d err", i), {err1, err0}, 2'b00);
    end
    idle_inputs();
  endtask

  initial begin
    int lo_cnt, hi_cnt, k;
    logic rose, got_err, seen0, seen1;

    // Lane 0 alone: A,G,T,C with last on C.
    vecs[0]  = mk(H, L, BASE_A, L, L, 2'b00, H, 2'b00, L, L);
    vecs[1]  = mk(H, L, BASE_G, L, L, 2'b00, L, 2'b00, L, L);
    vecs[2]  = mk(H, L, BASE_T, L, L, 2'b00, H, 2'b00, L, L);
    vecs[3]  = mk(H, H, BASE_C, L, L, 2'b00, L, 2'b00, L, L);
    vecs[4]  = mk(L, L, 2'b00,  L, L, 2'b00, H, 2'b00, L, L);
    vecs[5]  = mk(L, L, 2'b00,  L, L, 2'b00, L, BASE_A, H, L);
    vecs[6]  = mk(L, L, 2'b00,  L, L, 2'b00, H, 2'b00, H, L);
    vecs[7]  = mk(L, L, 2'b00,  L, L, 2'b00, L, BASE_G, H, L);
    vecs[8]  = mk(L, L, 2'b00,  L, L, 2'b00, H, 2'b00, H, L);
    vecs[9]  = mk(L, L, 2'b00,  L, L, 2'b00, L, BASE_T, H, L);
    vecs[10] = mk(L, L, 2'b00,  L, L, 2'b00, H, 2'b00, H, L);
    vecs[11] = mk(L, L, 2'b00,  L, L, 2'b00, L, BASE_C, H, L);
    vecs[12] = mk(L, L, 2'b00,  L, L, 2'b00, H, 2'b00, H, L);
    vecs[13] = mk(L, L, 2'b00,  L, L, 2'b00, L, 2'b00, L, L);
    // Both lanes: lane 0 A,G(last); lane 1 C,A(last).
    vecs[14] = mk(H, L, BASE_A, H, L, BASE_C, H, 2'b00, L, L);
    vecs[15] = mk(H, H, BASE_G, H, H, BASE_A, L, 2'b00, L, L);
    vecs[16] = mk(L, L, 2'b00,  L, L, 2'b00,  H, BASE_C, L, H);
    vecs[17] = mk(L, L, 2'b00,  L, L, 2'b00,  L, BASE_A, H, H);
    vecs[18] = mk(L, L, 2'b00,  L, L, 2'b00,  H, BASE_A, H, H);
    vecs[19] = mk(L, L, 2'b00,  L, L, 2'b00,  L, BASE_G, H, H);
    vecs[20] = mk(L, L, 2'b00,  L, L, 2'b00,  H, 2'b00, H, L);
    vecs[21] = mk(L, L, 2'b00,  L, L, 2'b00,  L, 2'b00, L, L);

    // Reset state.
    idle_inputs();
    err_clr = 0;
    rst = 1;
    tick();
    tick();
    check("reset phase", phase, 0);
    check("reset data_out", data_out, 0);
    check("reset en", {en1, en0}, 0);
    check("reset err", {err1, err0}, 0);
    check("reset busy", busy, 0);
    check("reset ready", {s1_ready, s0_ready}, 0);
    check("reset lane states", dbg_state, 0);
    rst = 0;

    // Single-lane sequence.
    run_vecs(0, 13);

    // Single base queued during the gap: measure the gap and the one-slot enable.
    lo_cnt = 1;
    rose = 0;
    s0_valid = 1; s0_base = BASE_G; s0_last = 1;
    for (int n = 0; n < 80 && !rose; n++) begin
      tick();
      idle_inputs();
      if (en0) rose = 1;
      else lo_cnt++;
    end
    check("single base en0 rise", rose, 1);
    check($sformatf("en0 gap low cycles %0d >= %0d", lo_cnt, 2 * GS), (lo_cnt >= 2 * GS), 1);
    check("single base data_out", data_out, BASE_G);
    check("single base phase", phase, 0);
    hi_cnt = 1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (en0) hi_cnt++;
      else break;
    end
    check("single base en0 high cycles", hi_cnt, 2);

    // Two lanes interleaved.
    do_reset();
    run_vecs(14, 21);

    // Lane 1 fills without last, streams, underruns while err_clr is held.
    do_reset();
    err_clr = 1;
    for (int i = 0; i < 16; i++) begin
      push_base(1, 2'(i), 1'b0);
      exp_q.push_back(2'(i));
    end
    check("lane1 ready low when full", s1_ready, 0);
    en1_hi_cnt = 0;
    got_err = 0;
    for (int n = 0; n < 120 && !got_err; n++) begin
      tick();
      if (phase && en1) begin
        if (exp_q.size() == 0) check("lane1 unexpected base", 1, 0);
        else check("lane1 streamed base", data_out, exp_q.pop_front());
      end
      if (err1) got_err = 1;
    end
    check("underrun sets err1 despite err_clr", got_err, 1);
    check("en1 low at underrun", en1, 0);
    check("en1 high cycles before underrun", en1_hi_cnt, 32);
    check("all lane1 bases streamed", exp_q.size(), 0);
    check("no err0", err0, 0);
    tick();
    check("err1 cleared by err_clr", err1, 0);
    err_clr = 0;
    en1_hi_cnt = 0;
    push_base(1, BASE_A, 1'b0);
    push_base(1, BASE_C, 1'b0);
    push_base(1, BASE_G, 1'b1);
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    check("busy clears after discard and gap", busy, 0);
    check("en1 low during discard", en1_hi_cnt, 0);
    check("err1 stays clear in discard", err1, 0);

    // Reset in mid-stream with a sticky error pending.
    do_reset();
    for (int i = 0; i < 16; i++) push_base(1, BASE_T, 1'b0);
    k = 0;
    while (err1 !== 1'b1 && k < 120) begin
      tick();
      k++;
    end
    check("lane1 underrun err1", err1, 1);
    repeat (5) tick();
    check("err1 sticky", err1, 1);
    push_base(0, BASE_A, 1'b0);
    push_base(0, BASE_G, 1'b1);
    k = 0;
    while (en0 !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("lane0 streaming before reset", en0, 1);
    rst = 1;
    tick();
    check("mid reset en", {en1, en0}, 0);
    check("mid reset busy", busy, 0);
    check("mid reset err", {err1, err0}, 0);
    check("mid reset phase", phase, 0);
    check("mid reset data_out", data_out, 0);
    check("mid reset ready", {s1_ready, s0_ready}, 0);
    rst = 0;
    s0_valid = 1; s0_base = BASE_T; s0_last = 1;
    s1_valid = 1; s1_base = BASE_C; s1_last = 1;
    tick();
    idle_inputs();
    seen0 = 0;
    seen1 = 0;
    for (int n = 0; n < 8; n++) begin
      if (en0) seen0 = 1;
      if (en1) seen1 = 1;
      tick();
    end
    check("lane0 accepted right after reset", seen0, 1);
    check("lane1 accepted right after reset", seen1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
